// File: rtl/ddr_channel_router_pkg.sv
// Shared widths and helpers for the multi-channel DDR AXI4 router.
package ddr_router_pkg;

    localparam int unsigned LEN_W   = 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned CACHE_W = 4;
    localparam int unsigned PROT_W  = 3;
    localparam int unsigned QOS_W   = 4;
    localparam int unsigned RESP_W  = 2;

    // Channel-select field width; a single channel still keeps a 1-bit field.
    function automatic int unsigned ch_w_f(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Outstanding counter must hold 0..max_out inclusive.
    function automatic int unsigned cnt_w_f(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

    function automatic int unsigned strb_w_f(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/ddr_channel_router_if.sv
// AXI4 bus bundle with N lanes flattened side by side; lane k sits at [k*W +: W].
interface ddr_channel_router_if #(
    parameter int unsigned N      = 1,
    parameter int unsigned ADDR_W = 34,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 16
);
    import ddr_router_pkg::*;

    localparam int unsigned STRB_W = DATA_W / 8;

    logic [N*ID_W-1:0]    awid;
    logic [N*ADDR_W-1:0]  awaddr;
    logic [N*LEN_W-1:0]   awlen;
    logic [N*SIZE_W-1:0]  awsize;
    logic [N*BURST_W-1:0] awburst;
    logic [N-1:0]         awlock;
    logic [N*CACHE_W-1:0] awcache;
    logic [N*PROT_W-1:0]  awprot;
    logic [N*QOS_W-1:0]   awqos;
    logic [N-1:0]         awvalid;
    logic [N-1:0]         awready;

    logic [N*DATA_W-1:0]  wdata;
    logic [N*STRB_W-1:0]  wstrb;
    logic [N-1:0]         wlast;
    logic [N-1:0]         wvalid;
    logic [N-1:0]         wready;

    logic [N*ID_W-1:0]    bid;
    logic [N*RESP_W-1:0]  bresp;
    logic [N-1:0]         bvalid;
    logic [N-1:0]         bready;

    logic [N*ID_W-1:0]    arid;
    logic [N*ADDR_W-1:0]  araddr;
    logic [N*LEN_W-1:0]   arlen;
    logic [N*SIZE_W-1:0]  arsize;
    logic [N*BURST_W-1:0] arburst;
    logic [N-1:0]         arlock;
    logic [N*CACHE_W-1:0] arcache;
    logic [N*PROT_W-1:0]  arprot;
    logic [N*QOS_W-1:0]   arqos;
    logic [N-1:0]         arvalid;
    logic [N-1:0]         arready;

    logic [N*ID_W-1:0]    rid;
    logic [N*DATA_W-1:0]  rdata;
    logic [N*RESP_W-1:0]  rresp;
    logic [N-1:0]         rlast;
    logic [N-1:0]         rvalid;
    logic [N-1:0]         rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/ddr_channel_router_route_fifo.sv
// Small synchronous FIFO holding the channel of each accepted AW until its last W beat.
module route_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);
    assign head_c  = mem[rd_ptr];

    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign do_pop  = pop && !empty_c;
    assign do_push = push && (!full_c || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/ddr_channel_router.sv
// Routes one AXI4 master onto NUM_CH DDR channels by address bits, keeping a single
// active channel per direction so responses stay in order regardless of ID.
module ddr_channel_router
    import ddr_router_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned ADDR_W    = 34,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ID_W      = 16,
    parameter int unsigned SEL_LSB   = 32,
    parameter int unsigned STRIP_SEL = 1,
    parameter int unsigned MAX_OUT   = 16,
    parameter int unsigned WQ_DEPTH  = 8
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    ddr_channel_router_if.slave   s_axi,
    ddr_channel_router_if.master  m_axi,
    output logic                  rd_busy,
    output logic                  wr_busy,
    output logic                  err_wq_ovf
);

    localparam int unsigned CH_W   = ch_w_f(NUM_CH);
    localparam int unsigned CNT_W  = cnt_w_f(MAX_OUT);
    localparam int unsigned STRB_W = strb_w_f(DATA_W);
    localparam logic [ADDR_W-1:0] SEL_MASK = (STRIP_SEL != 0 && NUM_CH > 1) ?
        (ADDR_W'((1 << CH_W) - 1) << SEL_LSB) : '0;

    logic             live;
    logic [CH_W-1:0]  ar_sel_c, aw_sel_c;
    logic [CNT_W-1:0] rd_cnt, rd_cnt_nxt, wr_cnt, wr_cnt_nxt;
    logic [CH_W-1:0]  rd_ch, wr_ch;
    logic             rd_allow_c, wr_allow_c;
    logic             ar_hs_c, r_last_hs_c, aw_hs_c, w_last_hs_c, b_hs_c;
    logic [CH_W-1:0]  wq_head_c;
    logic             wq_full_c, wq_empty_c;

    // Holds every handshake closed while in reset and for the first cycle after.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    assign ar_sel_c = (NUM_CH > 1) ? s_axi.araddr[SEL_LSB +: CH_W] : '0;
    assign aw_sel_c = (NUM_CH > 1) ? s_axi.awaddr[SEL_LSB +: CH_W] : '0;

    // Payload fan-out; only valid/ready are steered.
    assign m_axi.arid    = {NUM_CH{s_axi.arid}};
    assign m_axi.araddr  = {NUM_CH{s_axi.araddr & ~SEL_MASK}};
    assign m_axi.arlen   = {NUM_CH{s_axi.arlen}};
    assign m_axi.arsize  = {NUM_CH{s_axi.arsize}};
    assign m_axi.arburst = {NUM_CH{s_axi.arburst}};
    assign m_axi.arlock  = {NUM_CH{s_axi.arlock}};
    assign m_axi.arcache = {NUM_CH{s_axi.arcache}};
    assign m_axi.arprot  = {NUM_CH{s_axi.arprot}};
    assign m_axi.arqos   = {NUM_CH{s_axi.arqos}};
    assign m_axi.awid    = {NUM_CH{s_axi.awid}};
    assign m_axi.awaddr  = {NUM_CH{s_axi.awaddr & ~SEL_MASK}};
    assign m_axi.awlen   = {NUM_CH{s_axi.awlen}};
    assign m_axi.awsize  = {NUM_CH{s_axi.awsize}};
    assign m_axi.awburst = {NUM_CH{s_axi.awburst}};
    assign m_axi.awlock  = {NUM_CH{s_axi.awlock}};
    assign m_axi.awcache = {NUM_CH{s_axi.awcache}};
    assign m_axi.awprot  = {NUM_CH{s_axi.awprot}};
    assign m_axi.awqos   = {NUM_CH{s_axi.awqos}};
    assign m_axi.wdata   = {NUM_CH{s_axi.wdata}};
    assign m_axi.wstrb   = {NUM_CH{s_axi.wstrb}};
    assign m_axi.wlast   = {NUM_CH{s_axi.wlast}};

    assign rd_allow_c = live && (rd_cnt == '0 || rd_ch == ar_sel_c) && (rd_cnt < CNT_W'(MAX_OUT));
    assign wr_allow_c = live && (wr_cnt == '0 || wr_ch == aw_sel_c) && (wr_cnt < CNT_W'(MAX_OUT))
                        && !wq_full_c;

    always_comb begin
        s_axi.arready = 1'b0;
        m_axi.arvalid = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ar_sel_c == CH_W'(k)) begin
                m_axi.arvalid[k] = s_axi.arvalid[0] && rd_allow_c;
                s_axi.arready    = rd_allow_c && m_axi.arready[k];
            end
        end
    end

    always_comb begin
        s_axi.rvalid = 1'b0;
        s_axi.rid    = '0;
        s_axi.rdata  = '0;
        s_axi.rresp  = '0;
        s_axi.rlast  = 1'b0;
        m_axi.rready = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_ch == CH_W'(k)) begin
                s_axi.rvalid    = live && m_axi.rvalid[k];
                s_axi.rid       = m_axi.rid[k*ID_W +: ID_W];
                s_axi.rdata     = m_axi.rdata[k*DATA_W +: DATA_W];
                s_axi.rresp     = m_axi.rresp[k*RESP_W +: RESP_W];
                s_axi.rlast     = m_axi.rlast[k];
                m_axi.rready[k] = live && s_axi.rready[0];
            end
        end
    end

    always_comb begin
        s_axi.awready = 1'b0;
        m_axi.awvalid = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (aw_sel_c == CH_W'(k)) begin
                m_axi.awvalid[k] = s_axi.awvalid[0] && wr_allow_c;
                s_axi.awready    = wr_allow_c && m_axi.awready[k];
            end
        end
    end

    // W follows the queue head; an empty queue keeps W closed until its AW lands.
    always_comb begin
        s_axi.wready = 1'b0;
        m_axi.wvalid = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (wq_head_c == CH_W'(k)) begin
                m_axi.wvalid[k] = live && !wq_empty_c && s_axi.wvalid[0];
                s_axi.wready    = live && !wq_empty_c && m_axi.wready[k];
            end
        end
    end

    always_comb begin
        s_axi.bvalid = 1'b0;
        s_axi.bid    = '0;
        s_axi.bresp  = '0;
        m_axi.bready = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (wr_ch == CH_W'(k)) begin
                s_axi.bvalid    = live && m_axi.bvalid[k];
                s_axi.bid       = m_axi.bid[k*ID_W +: ID_W];
                s_axi.bresp     = m_axi.bresp[k*RESP_W +: RESP_W];
                m_axi.bready[k] = live && s_axi.bready[0];
            end
        end
    end

    assign ar_hs_c     = s_axi.arvalid[0] && s_axi.arready[0];
    assign r_last_hs_c = s_axi.rvalid[0] && s_axi.rready[0] && s_axi.rlast[0] && (rd_cnt != '0);
    assign aw_hs_c     = s_axi.awvalid[0] && s_axi.awready[0];
    assign w_last_hs_c = s_axi.wvalid[0] && s_axi.wready[0] && s_axi.wlast[0];
    assign b_hs_c      = s_axi.bvalid[0] && s_axi.bready[0] && (wr_cnt != '0);

    assign rd_cnt_nxt = rd_cnt + CNT_W'(ar_hs_c) - CNT_W'(r_last_hs_c);
    assign wr_cnt_nxt = wr_cnt + CNT_W'(aw_hs_c) - CNT_W'(b_hs_c);

    route_fifo #(
        .DEPTH (WQ_DEPTH),
        .WIDTH (CH_W)
    ) u_wq (
        .clk       (axi_aclk),
        .rst_n     (axi_aresetn),
        .push      (aw_hs_c),
        .push_data (aw_sel_c),
        .pop       (w_last_hs_c),
        .head_c    (wq_head_c),
        .full_c    (wq_full_c),
        .empty_c   (wq_empty_c)
    );

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rd_cnt     <= '0;
            rd_ch      <= '0;
            wr_cnt     <= '0;
            wr_ch      <= '0;
            rd_busy    <= 1'b0;
            wr_busy    <= 1'b0;
            err_wq_ovf <= 1'b0;
        end else begin
            rd_cnt  <= rd_cnt_nxt;
            wr_cnt  <= wr_cnt_nxt;
            rd_busy <= (rd_cnt_nxt != '0);
            wr_busy <= (wr_cnt_nxt != '0);
            if (ar_hs_c) begin
                rd_ch <= ar_sel_c;
            end
            if (aw_hs_c) begin
                wr_ch <= aw_sel_c;
            end
            if (aw_hs_c && wq_full_c && !w_last_hs_c) begin
                err_wq_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_channel_router.sv
// Directed bench for ddr_channel_router with a data scoreboard on the R and W paths.
module tb_ddr_channel_router;
    import ddr_router_pkg::*;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned ADDR_W = 34;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ID_W   = 16;

    logic axi_aclk = 1'b0;
    logic axi_aresetn;
    logic rd_busy, wr_busy, err_wq_ovf;

    int n_checks;
    int n_fail;
    logic [63:0] sb_q [$];

    ddr_channel_router_if #(.N(1), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) s_if ();
    ddr_channel_router_if #(.N(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) m_if ();

    ddr_channel_router #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
        .SEL_LSB(32), .STRIP_SEL(1), .MAX_OUT(16), .WQ_DEPTH(8)
    ) dut (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .s_axi       (s_if.slave),
        .m_axi       (m_if.master),
        .rd_busy     (rd_busy),
        .wr_busy     (wr_busy),
        .err_wq_ovf  (err_wq_ovf)
    );

    always #5 axi_aclk = ~axi_aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [63:0] obs);
        logic [63:0] exp;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed %0h expected nothing (scoreboard empty)", tag, obs);
        end else begin
            exp = sb_q.pop_front();
            check(tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        s_if.awid = '0; s_if.awaddr = '0; s_if.awlen = '0; s_if.awsize = 3'd3;
        s_if.awburst = 2'd1; s_if.awlock = '0; s_if.awcache = '0; s_if.awprot = '0;
        s_if.awqos = '0; s_if.awvalid = '0;
        s_if.wdata = '0; s_if.wstrb = '1; s_if.wlast = '0; s_if.wvalid = '0;
        s_if.bready = '1;
        s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = 3'd3;
        s_if.arburst = 2'd1; s_if.arlock = '0; s_if.arcache = '0; s_if.arprot = '0;
        s_if.arqos = '0; s_if.arvalid = '0;
        s_if.rready = '1;
        m_if.awready = '1; m_if.wready = '1; m_if.arready = '1;
        m_if.bid = '0; m_if.bresp = '0; m_if.bvalid = '0;
        m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = '0; m_if.rvalid = '0;
    endtask

    task automatic drive_ar(input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id, input logic [7:0] len);
        s_if.araddr = a; s_if.arid = id; s_if.arlen = len; s_if.arvalid = 1'b1;
    endtask

    task automatic drive_aw(input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id, input logic [7:0] len);
        s_if.awaddr = a; s_if.awid = id; s_if.awlen = len; s_if.awvalid = 1'b1;
    endtask

    task automatic drive_w(input logic [DATA_W-1:0] d, input logic last);
        s_if.wdata = d; s_if.wlast = last; s_if.wvalid = 1'b1;
    endtask

    task automatic drive_r(input int ch, input logic [DATA_W-1:0] d, input logic [ID_W-1:0] id, input logic last);
        m_if.rvalid = '0; m_if.rlast = '0;
        m_if.rvalid[ch] = 1'b1;
        m_if.rlast[ch] = last;
        m_if.rdata[ch*DATA_W +: DATA_W] = d;
        m_if.rid[ch*ID_W +: ID_W] = id;
    endtask

    task automatic drive_b(input int ch, input logic [ID_W-1:0] id);
        m_if.bvalid = '0;
        m_if.bvalid[ch] = 1'b1;
        m_if.bid[ch*ID_W +: ID_W] = id;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        idle_inputs();
        axi_aresetn = 1'b0;
        repeat (3) @(posedge axi_aclk);
        #1;

        // Reset: upstream valids and downstream readies high, router must stay closed.
        s_if.arvalid = 1'b1; s_if.awvalid = 1'b1; s_if.wvalid = 1'b1;
        settle();
        check("rst_s_arready", s_if.arready, 0);
        check("rst_s_awready", s_if.awready, 0);
        check("rst_s_wready", s_if.wready, 0);
        check("rst_m_arvalid", m_if.arvalid, 0);
        check("rst_m_awvalid", m_if.awvalid, 0);
        check("rst_m_wvalid", m_if.wvalid, 0);
        check("rst_rd_busy", rd_busy, 0);
        check("rst_wr_busy", wr_busy, 0);
        check("rst_err", err_wq_ovf, 0);
        idle_inputs();
        axi_aresetn = 1'b1;
        tick();
        tick();

        // Read routing to ch1 with select stripping; noise on ch0 must not leak.
        drive_ar(34'h1_0000_0000, 16'h0005, 8'd3);
        settle();
        check("rt_m_arvalid", m_if.arvalid, 4'b0010);
        check("rt_m_araddr", m_if.araddr[1*ADDR_W +: ADDR_W], 0);
        check("rt_m_arlen", m_if.arlen[1*8 +: 8], 3);
        check("rt_s_arready", s_if.arready, 1);
        tick();
        s_if.arvalid = 1'b0;
        check("rt_rd_busy", rd_busy, 1);
        for (int i = 0; i < 4; i++) begin
            drive_r(1, 64'hA000 + 64'(i), 16'h0005, (i == 3));
            m_if.rvalid[0] = 1'b1;
            m_if.rdata[0 +: DATA_W] = 64'hDEAD;
            sb_q.push_back(64'hA000 + 64'(i));
            settle();
            check("rt_s_rvalid", s_if.rvalid, 1);
            check("rt_m_rready", m_if.rready, 4'b0010);
            check("rt_s_rlast", s_if.rlast, (i == 3) ? 1 : 0);
            sb_check("rt_s_rdata", s_if.rdata);
            tick();
        end
        m_if.rvalid = '0;
        check("rt_rd_idle", rd_busy, 0);

        // Read channel switch stalls until ch0 returns its last beat.
        drive_ar(34'h0_0000_0100, 16'h0007, 8'd0);
        settle();
        check("sw_first_arready", s_if.arready, 1);
        tick();
        drive_ar(34'h2_0000_0040, 16'h0008, 8'd0);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("sw_stall_arready", s_if.arready, 0);
            check("sw_stall_arvalid", m_if.arvalid, 0);
            tick();
        end
        drive_r(0, 64'hB0, 16'h0007, 1'b1);
        sb_q.push_back(64'hB0);
        settle();
        check("sw_lastbeat_arready", s_if.arready, 0);
        sb_check("sw_ch0_rdata", s_if.rdata);
        tick();
        m_if.rvalid = '0;
        settle();
        check("sw_after_arready", s_if.arready, 1);
        check("sw_after_arvalid", m_if.arvalid, 4'b0100);
        check("sw_after_araddr", m_if.araddr[2*ADDR_W +: ADDR_W], 34'h40);
        tick();
        s_if.arvalid = 1'b0;
        drive_r(2, 64'hC0, 16'h0008, 1'b1);
        sb_q.push_back(64'hC0);
        settle();
        sb_check("sw_ch2_rdata", s_if.rdata);
        tick();
        m_if.rvalid = '0;
        check("sw_rd_idle", rd_busy, 0);

        // Write ordering: two AWs to ch3, two 2-beat bursts.
        drive_aw(34'h3_0000_0000, 16'h0011, 8'd1);
        settle();
        check("wo_m_awvalid", m_if.awvalid, 4'b1000);
        check("wo_s_awready", s_if.awready, 1);
        check("wo_m_awaddr", m_if.awaddr[3*ADDR_W +: ADDR_W], 0);
        tick();
        drive_aw(34'h3_0000_0080, 16'h0012, 8'd1);
        settle();
        check("wo_s_awready2", s_if.awready, 1);
        tick();
        s_if.awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_w(64'hD000 + 64'(i), (i % 2 == 1));
            sb_q.push_back(64'hD000 + 64'(i));
            settle();
            check("wo_m_wvalid", m_if.wvalid, 4'b1000);
            check("wo_s_wready", s_if.wready, 1);
            sb_check("wo_m_wdata", m_if.wdata[3*DATA_W +: DATA_W]);
            tick();
        end
        s_if.wvalid = 1'b0;
        check("wo_wr_busy", wr_busy, 1);
        drive_b(3, 16'h0011);
        settle();
        check("wo_s_bvalid", s_if.bvalid, 1);
        check("wo_s_bid1", s_if.bid, 16'h0011);
        tick();
        drive_b(3, 16'h0012);
        settle();
        check("wo_s_bid2", s_if.bid, 16'h0012);
        tick();
        m_if.bvalid = '0;
        check("wo_wr_idle", wr_busy, 0);

        // W presented before its AW is held off.
        drive_w(64'hE0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            settle();
            check("wa_early_wready", s_if.wready, 0);
            check("wa_early_wvalid", m_if.wvalid, 0);
            tick();
        end
        drive_aw(34'h1_0000_0000, 16'h0021, 8'd0);
        settle();
        check("wa_aw_cycle_wready", s_if.wready, 0);
        tick();
        s_if.awvalid = 1'b0;
        sb_q.push_back(64'hE0);
        settle();
        check("wa_wready", s_if.wready, 1);
        check("wa_m_wvalid", m_if.wvalid, 4'b0010);
        sb_check("wa_m_wdata", m_if.wdata[1*DATA_W +: DATA_W]);
        tick();
        s_if.wvalid = 1'b0;
        drive_b(1, 16'h0021);
        settle();
        check("wa_s_bid", s_if.bid, 16'h0021);
        tick();
        m_if.bvalid = '0;
        check("wa_wr_idle", wr_busy, 0);

        // Outstanding read limit: 16 accepted, 17th stalls.
        for (int i = 0; i < 16; i++) begin
            drive_ar(34'h0_0000_0000, ID_W'(i), 8'd0);
            settle();
            check("lim_ar_accept", s_if.arready, 1);
            tick();
        end
        settle();
        check("lim_ar17_arready", s_if.arready, 0);
        check("lim_ar17_arvalid", m_if.arvalid, 0);
        s_if.arvalid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_r(0, 64'hF00 + 64'(i), ID_W'(i), 1'b1);
            sb_q.push_back(64'hF00 + 64'(i));
            settle();
            sb_check("lim_rdata", s_if.rdata);
            tick();
        end
        m_if.rvalid = '0;
        check("lim_rd_idle", rd_busy, 0);

        // Write queue limit: 8 AWs with W withheld, 9th stalls, no overflow.
        for (int i = 0; i < 8; i++) begin
            drive_aw(34'h0_0000_1000, ID_W'(i), 8'd0);
            settle();
            check("wq_aw_accept", s_if.awready, 1);
            tick();
        end
        settle();
        check("wq_aw9_awready", s_if.awready, 0);
        check("wq_aw9_awvalid", m_if.awvalid, 0);
        check("wq_err", err_wq_ovf, 0);
        s_if.awvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_w(64'h100 + 64'(i), 1'b1);
            settle();
            check("wq_m_wvalid", m_if.wvalid, 4'b0001);
            tick();
        end
        s_if.wvalid = 1'b0;
        settle();
        check("wq_drained_wready", s_if.wready, 0);
        drive_b(0, 16'h0000);
        repeat (8) tick();
        m_if.bvalid = '0;
        check("wq_wr_idle", wr_busy, 0);
        check("wq_err_final", err_wq_ovf, 0);

        // Reset in the middle of traffic.
        drive_ar(34'h1_0000_0000, 16'h0001, 8'd3);
        tick();
        drive_aw(34'h2_0000_0000, 16'h0002, 8'd0);
        tick();
        drive_w(64'h55, 1'b1);
        settle();
        check("mr_pre_arvalid", m_if.arvalid, 4'b0010);
        check("mr_pre_wvalid", m_if.wvalid, 4'b0100);
        check("mr_pre_rd_busy", rd_busy, 1);
        #2;
        axi_aresetn = 1'b0;
        #1;
        check("mr_arvalid", m_if.arvalid, 0);
        check("mr_awvalid", m_if.awvalid, 0);
        check("mr_wvalid", m_if.wvalid, 0);
        check("mr_s_arready", s_if.arready, 0);
        check("mr_s_wready", s_if.wready, 0);
        check("mr_rd_busy", rd_busy, 0);
        check("mr_wr_busy", wr_busy, 0);
        idle_inputs();
        tick();
        axi_aresetn = 1'b1;
        tick();
        tick();
        check("mr_post_rd_busy", rd_busy, 0);
        check("mr_post_wr_busy", wr_busy, 0);
        drive_ar(34'h2_0000_0000, 16'h0003, 8'd0);
        settle();
        check("mr_post_arvalid", m_if.arvalid, 4'b0100);
        check("mr_post_arready", s_if.arready, 1);
        tick();
        s_if.arvalid = 1'b0;
        drive_r(2, 64'h77, 16'h0003, 1'b1);
        sb_q.push_back(64'h77);
        settle();
        sb_check("mr_post_rdata", s_if.rdata);
        tick();
        m_if.rvalid = '0;
        check("mr_post_idle", rd_busy, 0);

        check("sb_drained", 64'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
